axi_gmem_bram_slave: RTL and testbench
======================================

// Module: axi_gmem_bram_slave
// PURPOSE
//  AXI4 memory slave that answers the kernel's gmem master port (AW/W/B, AR/R).
//  Serves INCR bursts from an internal word array: one read and one write burst in flight.
//  Used as the on-chip host-memory stand-in for GLM kernel simulation and loopback builds.
// PARAMETERS
//  C_ID_WIDTH    1    AXI ID width; IDs are echoed on B/R.
//  C_ADDR_WIDTH  42   AXI byte-address width.
//  C_DATA_WIDTH  512  Data width; one beat is one array word (64 B).
//  C_MEM_WORDS   4096 Array depth in words; power of two.
// PORTS
//  ap_clk        in   1          Clock.
//  ap_rst        in   1          Synchronous active-high reset.
//  s_axi_AWVALID/AWREADY in/out 1; AWADDR in C_ADDR_WIDTH; AWID in C_ID_WIDTH; AWLEN in 8.
//  s_axi_WVALID/WREADY in/out 1; WDATA in C_DATA_WIDTH; WSTRB in C_DATA_WIDTH/8; WLAST in 1.
//  s_axi_BVALID out 1; BREADY in 1; BRESP out 2; BID out C_ID_WIDTH.
//  s_axi_ARVALID/ARREADY in/out 1; ARADDR in C_ADDR_WIDTH; ARID in C_ID_WIDTH; ARLEN in 8.
//  s_axi_RVALID out 1; RREADY in 1; RDATA out C_DATA_WIDTH; RRESP out 2; RLAST out 1; RID out C_ID_WIDTH.
//  err_wlast     out  1          Sticky: WLAST disagreed with the AWLEN beat count.
// BEHAVIOUR
//  Reset: all VALID/READY outputs 0, BRESP/RRESP 0, RLAST 0, err_wlast 0. Array contents are not reset.
//  Word index = addr[log2(C_MEM_WORDS)+5:6]; addr[5:0] ignored. SIZE and BURST are not ports.
//  All bursts are INCR, full width, with beats = AxLEN+1.
//  Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
//   W_IDLE: AWREADY=1. On an AW handshake, latch index/ID/count and go to W_DATA. AWREADY is 0 in the other states.
//   W_DATA: WREADY=1. On each W handshake, write the byte lanes where WSTRB=1, then index+1 and count-1.
//     On the last counted beat, go to W_RESP.
//     If WLAST=1 before the last counted beat, or WLAST=0 on the last counted beat, set err_wlast.
//     The internal count alone ends the burst.
//   W_RESP: BVALID=1 with BID latched. BVALID holds until BREADY; the handshake returns to W_IDLE.
//  Read FSM, R_IDLE -> R_DATA -> R_IDLE:
//   R_IDLE: ARREADY=1. On an AR handshake, register RDATA=mem[index] and RVALID=1 in the next cycle (latency 1).
//   R_DATA: RDATA/RLAST/RRESP stay stable while RVALID & !RREADY.
//     On a handshake that is not the last beat, load mem[index+1] the same edge (1 beat/cycle).
//     RLAST=1 exactly on beat AxLEN+1. The handshake on that beat clears RVALID and returns to R_IDLE.
//     The next AR is accepted no earlier than the following cycle.
//  Read/write collision on the same word in the same cycle: the read returns the old data.
//  Write strobes apply the next edge.
//  The index wraps modulo C_MEM_WORDS mid-burst; AXI 4 KB boundary checks are not enforced.
//  AWLEN=0 / ARLEN=0: a single beat, with RLAST=1 on the first beat.
//  Reset mid-burst: both FSMs return to IDLE on the next edge and the in-flight transfer is dropped.
//   Array writes already done remain.
// CONFIGURATION
//  AXI_GMEM_SLV_RANGE_CHECK_EN defined: the burst start addr >> 6 is compared with C_MEM_WORDS.
//   If the start word is >= C_MEM_WORDS, the burst is flagged.
//   Flagged write: all beats are accepted and discarded, and BRESP=2'b10 (SLVERR).
//   Flagged read: every beat returns RDATA=0 and RRESP=2'b10.
//  Undefined: the address is truncated to the index (aliasing), and all responses are OKAY (2'b00).
// TESTING
//  1 Write AWADDR=0x40, AWLEN=3, WSTRB all 1, data k+1 -> BRESP=0 after 4 beats.
//    Read back AR 0x40, LEN=3 -> beats 1..4, RLAST only on beat 4.
//  2 Write word 5 with WSTRB=0x...0F, then read -> only bytes 0..3 change; other bytes keep their old value.
//  3 Read LEN=7 with RREADY toggling 1,0,0,1... -> RDATA/RLAST stable while stalled; 8 beats, in order, with none lost.
//  4 Write LEN=1 with WLAST=1 on beat 1 -> err_wlast=1; burst still takes 2 beats; B follows beat 2.
//  5 Assert ap_rst for 1 cycle mid read burst (beat 3 of 8) -> RVALID=0, ARREADY=1 the next cycle.
//    A new AR is serviced correctly.
//  6 RANGE_CHECK_EN, C_MEM_WORDS=4096, ARADDR=0x40000 -> RRESP=2'b10, RDATA=0.
//    Without the macro, the same read returns word 0.

Source files
------------

// File: rtl/axi_gmem_bram_slave_if.sv
// AXI4 gmem bus bundle (AW/W/B/AR/R) between a kernel master port and axi_gmem_bram_slave.
interface axi_gmem_bram_slave_if #(
  parameter int C_ID_WIDTH   = 1,
  parameter int C_ADDR_WIDTH = 42,
  parameter int C_DATA_WIDTH = 512
) ();
  logic                      AWVALID, AWREADY;
  logic [C_ADDR_WIDTH-1:0]   AWADDR;
  logic [C_ID_WIDTH-1:0]     AWID;
  logic [7:0]                AWLEN;
  logic                      WVALID, WREADY, WLAST;
  logic [C_DATA_WIDTH-1:0]   WDATA;
  logic [C_DATA_WIDTH/8-1:0] WSTRB;
  logic                      BVALID, BREADY;
  logic [1:0]                BRESP;
  logic [C_ID_WIDTH-1:0]     BID;
  logic                      ARVALID, ARREADY;
  logic [C_ADDR_WIDTH-1:0]   ARADDR;
  logic [C_ID_WIDTH-1:0]     ARID;
  logic [7:0]                ARLEN;
  logic                      RVALID, RREADY, RLAST;
  logic [C_DATA_WIDTH-1:0]   RDATA;
  logic [1:0]                RRESP;
  logic [C_ID_WIDTH-1:0]     RID;

  modport slave (
    input  AWVALID, AWADDR, AWID, AWLEN, output AWREADY,
    input  WVALID, WDATA, WSTRB, WLAST, output WREADY,
    output BVALID, BRESP, BID, input BREADY,
    input  ARVALID, ARADDR, ARID, ARLEN, output ARREADY,
    output RVALID, RDATA, RRESP, RLAST, RID, input RREADY
  );

  modport master (
    output AWVALID, AWADDR, AWID, AWLEN, input AWREADY,
    output WVALID, WDATA, WSTRB, WLAST, input WREADY,
    input  BVALID, BRESP, BID, output BREADY,
    output ARVALID, ARADDR, ARID, ARLEN, input ARREADY,
    input  RVALID, RDATA, RRESP, RLAST, RID, output RREADY
  );
endinterface

// File: rtl/axi_gmem_bram_slave.sv
// AXI4 INCR-burst memory slave backed by an on-chip word array, one read and one write burst in flight.
// Optional macro AXI_GMEM_SLV_RANGE_CHECK_EN: out-of-range bursts answer SLVERR instead of aliasing.
module axi_gmem_bram_slave #(
  parameter int C_ID_WIDTH   = 1,
  parameter int C_ADDR_WIDTH = 42,
  parameter int C_DATA_WIDTH = 512,
  parameter int C_MEM_WORDS  = 4096
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  axi_gmem_bram_slave_if.slave  s_axi,
  output logic                  err_wlast
);
  localparam int IDX_W  = $clog2(C_MEM_WORDS);
  localparam int STRB_W = C_DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [C_DATA_WIDTH-1:0] mem [C_MEM_WORDS];

  w_state_t         w_state;
  r_state_t         r_state;
  logic [IDX_W-1:0] w_idx, r_idx;
  logic [7:0]       w_cnt, r_cnt;
  logic             w_oob, r_oob;
  logic             aw_oob, ar_oob;
  logic             mem_we;
  logic             unused_addr;

`ifdef AXI_GMEM_SLV_RANGE_CHECK_EN
  assign aw_oob = |s_axi.AWADDR[C_ADDR_WIDTH-1:IDX_W+6];
  assign ar_oob = |s_axi.ARADDR[C_ADDR_WIDTH-1:IDX_W+6];
`else
  assign aw_oob = 1'b0;
  assign ar_oob = 1'b0;
`endif

  // Sub-word offset and high address bits are deliberately ignored in the aliasing build.
  assign unused_addr = ^{s_axi.AWADDR, s_axi.ARADDR};

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      w_state       <= W_IDLE;
      s_axi.AWREADY <= 1'b0;
      s_axi.WREADY  <= 1'b0;
      s_axi.BVALID  <= 1'b0;
      s_axi.BRESP   <= 2'b00;
      err_wlast     <= 1'b0;
      w_oob         <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (s_axi.AWVALID && s_axi.AWREADY) begin
            w_idx         <= s_axi.AWADDR[IDX_W+5:6];
            w_cnt         <= s_axi.AWLEN;
            s_axi.BID     <= s_axi.AWID;
            w_oob         <= aw_oob;
            s_axi.AWREADY <= 1'b0;
            s_axi.WREADY  <= 1'b1;
            w_state       <= W_DATA;
          end else begin
            s_axi.AWREADY <= 1'b1;
          end
        end
        // The beat counter alone ends the burst; WLAST is only checked for consistency.
        W_DATA: begin
          if (s_axi.WVALID && s_axi.WREADY) begin
            if (s_axi.WLAST != (w_cnt == 8'd0)) err_wlast <= 1'b1;
            w_idx <= w_idx + 1'b1;
            w_cnt <= w_cnt - 1'b1;
            if (w_cnt == 8'd0) begin
              s_axi.WREADY <= 1'b0;
              s_axi.BVALID <= 1'b1;
              s_axi.BRESP  <= w_oob ? 2'b10 : 2'b00;
              w_state      <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi.BREADY) begin
            s_axi.BVALID  <= 1'b0;
            s_axi.AWREADY <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign mem_we = (w_state == W_DATA) && s_axi.WVALID && s_axi.WREADY && !w_oob && !ap_rst;

  always_ff @(posedge ap_clk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi.WSTRB[b]) mem[w_idx][8*b +: 8] <= s_axi.WDATA[8*b +: 8];
      end
    end
  end

  // r_idx always points at the word to load on the next accepted beat.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state       <= R_IDLE;
      s_axi.ARREADY <= 1'b0;
      s_axi.RVALID  <= 1'b0;
      s_axi.RRESP   <= 2'b00;
      s_axi.RLAST   <= 1'b0;
      r_oob         <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_axi.ARVALID && s_axi.ARREADY) begin
            s_axi.RDATA   <= ar_oob ? '0 : mem[s_axi.ARADDR[IDX_W+5:6]];
            s_axi.RRESP   <= ar_oob ? 2'b10 : 2'b00;
            s_axi.RLAST   <= (s_axi.ARLEN == 8'd0);
            s_axi.RID     <= s_axi.ARID;
            s_axi.RVALID  <= 1'b1;
            s_axi.ARREADY <= 1'b0;
            r_idx         <= s_axi.ARADDR[IDX_W+5:6] + 1'b1;
            r_cnt         <= s_axi.ARLEN;
            r_oob         <= ar_oob;
            r_state       <= R_DATA;
          end else begin
            s_axi.ARREADY <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi.RVALID && s_axi.RREADY) begin
            if (s_axi.RLAST) begin
              s_axi.RVALID  <= 1'b0;
              s_axi.RLAST   <= 1'b0;
              s_axi.ARREADY <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              s_axi.RDATA <= r_oob ? '0 : mem[r_idx];
              s_axi.RLAST <= (r_cnt == 8'd1);
              r_idx       <= r_idx + 1'b1;
              r_cnt       <= r_cnt - 1'b1;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_gmem_bram_slave.sv
// Directed self-checking bench for axi_gmem_bram_slave: bursts, strobes, stalls, WLAST error, reset, wrap, range.
module tb_axi_gmem_bram_slave;
  localparam int IW = 1;
  localparam int AW = 42;
  localparam int DW = 512;
  localparam int MW = 4096;

  logic ap_clk = 1'b0;
  logic ap_rst;
  logic err_wlast;

  axi_gmem_bram_slave_if #(.C_ID_WIDTH(IW), .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW)) s_axi ();

  axi_gmem_bram_slave #(
    .C_ID_WIDTH(IW), .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_MEM_WORDS(MW)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .s_axi(s_axi), .err_wlast(err_wlast)
  );

  always #5 ap_clk = ~ap_clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0]   rd_data [16];
  logic            rd_last [16];
  logic [1:0]      rd_resp [16];
  logic [IW-1:0]   rd_id;
  int              rd_n;
  logic            rd_to;
  logic            rd_first_valid;

  localparam logic [DW-1:0] STALL_BASE = {8{64'hC0DE_0000_0000_0010}};
  localparam logic [DW-1:0] WRAP_BASE  = {8{64'h5A5A_0000_0000_0F00}};

  task automatic issue_ar(input logic [AW-1:0] addr, input logic [IW-1:0] id, input logic [7:0] len,
                          output logic timeout);
    int cyc = 0;
    timeout = 1'b0;
    s_axi.ARVALID = 1'b1; s_axi.ARADDR = addr; s_axi.ARID = id; s_axi.ARLEN = len;
    while (!s_axi.ARREADY && cyc < 50) begin @(negedge ap_clk); cyc++; end
    if (cyc >= 50) timeout = 1'b1;
    @(negedge ap_clk);
    s_axi.ARVALID = 1'b0;
  endtask

  task automatic read_burst(input logic [AW-1:0] addr, input logic [IW-1:0] id, input logic [7:0] len);
    int cyc = 0;
    logic to;
    issue_ar(addr, id, len, to);
    rd_to = to;
    rd_first_valid = s_axi.RVALID;
    rd_n = 0;
    s_axi.RREADY = 1'b1;
    while (rd_n <= int'(len) && cyc < 200) begin
      if (s_axi.RVALID) begin
        rd_data[rd_n] = s_axi.RDATA; rd_last[rd_n] = s_axi.RLAST;
        rd_resp[rd_n] = s_axi.RRESP; rd_id = s_axi.RID;
        rd_n++;
      end
      @(negedge ap_clk); cyc++;
    end
    s_axi.RREADY = 1'b0;
    if (rd_n <= int'(len)) rd_to = 1'b1;
  endtask

  task automatic write_burst(input logic [AW-1:0] addr, input logic [IW-1:0] id, input logic [7:0] len,
                             input logic [DW-1:0] base, input logic [DW/8-1:0] strb, input int early_last,
                             output logic [1:0] bresp, output logic [IW-1:0] bid,
                             output logic timeout, output logic b_early);
    int cyc = 0;
    timeout = 1'b0; b_early = 1'b0; bresp = 2'bxx; bid = 'x;
    s_axi.AWVALID = 1'b1; s_axi.AWADDR = addr; s_axi.AWID = id; s_axi.AWLEN = len;
    while (!s_axi.AWREADY && cyc < 50) begin @(negedge ap_clk); cyc++; end
    if (cyc >= 50) timeout = 1'b1;
    @(negedge ap_clk);
    s_axi.AWVALID = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      s_axi.WVALID = 1'b1; s_axi.WDATA = base + DW'(k); s_axi.WSTRB = strb;
      s_axi.WLAST = (early_last >= 0) ? (k == early_last) : (k == int'(len));
      cyc = 0;
      while (!s_axi.WREADY && cyc < 50) begin @(negedge ap_clk); cyc++; end
      if (cyc >= 50) timeout = 1'b1;
      @(negedge ap_clk);
      if (k < int'(len) && s_axi.BVALID) b_early = 1'b1;
    end
    s_axi.WVALID = 1'b0; s_axi.WLAST = 1'b0;
    cyc = 0;
    while (!s_axi.BVALID && cyc < 50) begin @(negedge ap_clk); cyc++; end
    if (cyc >= 50) timeout = 1'b1;
    bresp = s_axi.BRESP; bid = s_axi.BID;
    s_axi.BREADY = 1'b1;
    @(negedge ap_clk);
    s_axi.BREADY = 1'b0;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    repeat (2) @(negedge ap_clk);
    n_checks++;
    if ({s_axi.AWREADY, s_axi.WREADY, s_axi.BVALID, s_axi.ARREADY, s_axi.RVALID, s_axi.RLAST} !== 6'b0) begin
      n_fail++; $display("[TB] FAIL reset_handshake: got %b expected 000000",
        {s_axi.AWREADY, s_axi.WREADY, s_axi.BVALID, s_axi.ARREADY, s_axi.RVALID, s_axi.RLAST});
    end
    n_checks++;
    if ({s_axi.BRESP, s_axi.RRESP, err_wlast} !== 5'b0) begin
      n_fail++; $display("[TB] FAIL reset_resp: got %b expected 00000", {s_axi.BRESP, s_axi.RRESP, err_wlast});
    end
    ap_rst = 1'b0;
    @(negedge ap_clk);
    n_checks++;
    if ({s_axi.AWREADY, s_axi.ARREADY} !== 2'b11) begin
      n_fail++; $display("[TB] FAIL idle_ready: got %b expected 11", {s_axi.AWREADY, s_axi.ARREADY});
    end
  endtask

  task automatic test_burst_rw();
    logic [1:0] bresp; logic [IW-1:0] bid; logic to, be;
    write_burst(42'h40, 1'b1, 8'd3, 512'd1, '1, -1, bresp, bid, to, be);
    n_checks++;
    if ({to, be, bresp, bid} !== {1'b0, 1'b0, 2'b00, 1'b1}) begin
      n_fail++; $display("[TB] FAIL burst_write_b: got to=%b early=%b resp=%b id=%b expected 0 0 00 1", to, be, bresp, bid);
    end
    read_burst(42'h40, 1'b1, 8'd3);
    n_checks++;
    if ({rd_to, rd_first_valid, rd_id} !== 3'b011 || rd_n != 4) begin
      n_fail++; $display("[TB] FAIL burst_read_ctl: got to=%b v=%b id=%b n=%0d expected 0 1 1 4", rd_to, rd_first_valid, rd_id, rd_n);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (rd_data[k] !== DW'(k + 1) || rd_last[k] !== (k == 3) || rd_resp[k] !== 2'b00) begin
        n_fail++; $display("[TB] FAIL burst_beat%0d: got data=%0h last=%b resp=%b expected %0d %b 00", k, rd_data[k], rd_last[k], rd_resp[k], k + 1, k == 3);
      end
    end
    n_checks++;
    if (s_axi.RVALID !== 1'b0) begin
      n_fail++; $display("[TB] FAIL burst_rvalid_end: got %b expected 0", s_axi.RVALID);
    end
  endtask

  task automatic test_strobe();
    logic [1:0] bresp; logic [IW-1:0] bid; logic to, be;
    logic [DW-1:0] old_d, exp_d;
    old_d = {16{32'hA5A5_5A5A}};
    write_burst(42'h140, 1'b0, 8'd0, old_d, '1, -1, bresp, bid, to, be);
    write_burst(42'h140, 1'b0, 8'd0, {16{32'h1234_5678}}, 64'h0F, -1, bresp, bid, to, be);
    exp_d = {old_d[DW-1:32], 32'h1234_5678};
    read_burst(42'h140, 1'b0, 8'd0);
    n_checks++;
    if (rd_n != 1 || rd_data[0] !== exp_d || rd_last[0] !== 1'b1) begin
      n_fail++; $display("[TB] FAIL strobe_word5: got n=%0d last=%b data=%h expected 1 1 %h", rd_n, rd_last[0], rd_data[0], exp_d);
    end
  endtask

  task automatic test_read_stall();
    logic [1:0] bresp; logic [IW-1:0] bid; logic to, be;
    logic [DW-1:0] hold_d; logic hold_l, stalled;
    int n = 0, p = 0, cyc = 0;
    write_burst(42'h400, 1'b0, 8'd7, STALL_BASE, '1, -1, bresp, bid, to, be);
    issue_ar(42'h400, 1'b0, 8'd7, to);
    stalled = 1'b0; hold_d = '0; hold_l = 1'b0;
    while (n < 8 && cyc < 200) begin
      if (s_axi.RVALID && stalled) begin
        n_checks++;
        if (s_axi.RDATA !== hold_d || s_axi.RLAST !== hold_l) begin
          n_fail++; $display("[TB] FAIL stall_stable: got last=%b data=%h expected %b %h", s_axi.RLAST, s_axi.RDATA, hold_l, hold_d);
        end
      end
      s_axi.RREADY = (p % 3 == 0);
      if (s_axi.RVALID) begin
        if (s_axi.RREADY) begin
          rd_data[n] = s_axi.RDATA; rd_last[n] = s_axi.RLAST; n++; stalled = 1'b0;
        end else begin
          stalled = 1'b1; hold_d = s_axi.RDATA; hold_l = s_axi.RLAST;
        end
      end
      p++;
      @(negedge ap_clk); cyc++;
    end
    s_axi.RREADY = 1'b0;
    n_checks++;
    if (n != 8 || to !== 1'b0 || s_axi.RVALID !== 1'b0) begin
      n_fail++; $display("[TB] FAIL stall_count: got beats=%0d to=%b rvalid=%b expected 8 0 0", n, to, s_axi.RVALID);
    end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (k < n && (rd_data[k] !== STALL_BASE + DW'(k) || rd_last[k] !== (k == 7))) begin
        n_fail++; $display("[TB] FAIL stall_beat%0d: got last=%b data=%h expected %b %h", k, rd_last[k], rd_data[k], k == 7, STALL_BASE + DW'(k));
      end
    end
  endtask

  task automatic test_wlast_err();
    logic [1:0] bresp; logic [IW-1:0] bid; logic to, be;
    n_checks++;
    if (err_wlast !== 1'b0) begin
      n_fail++; $display("[TB] FAIL wlast_clean: got %b expected 0", err_wlast);
    end
    write_burst(42'h800, 1'b1, 8'd1, 512'h77, '1, 0, bresp, bid, to, be);
    n_checks++;
    if ({err_wlast, to, be, bresp, bid} !== {1'b1, 1'b0, 1'b0, 2'b00, 1'b1}) begin
      n_fail++; $display("[TB] FAIL wlast_err: got err=%b to=%b early=%b resp=%b id=%b expected 1 0 0 00 1", err_wlast, to, be, bresp, bid);
    end
    read_burst(42'h800, 1'b0, 8'd1);
    n_checks++;
    if (rd_n != 2 || rd_data[0] !== 512'h77 || rd_data[1] !== 512'h78) begin
      n_fail++; $display("[TB] FAIL wlast_data: got n=%0d d0=%0h d1=%0h expected 2 77 78", rd_n, rd_data[0], rd_data[1]);
    end
  endtask

  task automatic test_reset_mid_read();
    logic to;
    issue_ar(42'h400, 1'b0, 8'd7, to);
    s_axi.RREADY = 1'b1;
    repeat (2) @(negedge ap_clk);
    n_checks++;
    if (s_axi.RVALID !== 1'b1 || s_axi.RDATA !== STALL_BASE + DW'(2)) begin
      n_fail++; $display("[TB] FAIL midrd_beat3: got v=%b data=%h expected 1 %h", s_axi.RVALID, s_axi.RDATA, STALL_BASE + DW'(2));
    end
    ap_rst = 1'b1; s_axi.RREADY = 1'b0;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    n_checks++;
    if ({s_axi.RVALID, s_axi.RLAST, err_wlast} !== 3'b000) begin
      n_fail++; $display("[TB] FAIL midrd_rst: got rvalid/rlast/err=%b expected 000", {s_axi.RVALID, s_axi.RLAST, err_wlast});
    end
    @(negedge ap_clk);
    n_checks++;
    if ({s_axi.ARREADY, s_axi.RVALID} !== 2'b10) begin
      n_fail++; $display("[TB] FAIL midrd_idle: got arready/rvalid=%b expected 10", {s_axi.ARREADY, s_axi.RVALID});
    end
    read_burst(42'h40, 1'b0, 8'd1);
    n_checks++;
    if (rd_n != 2 || rd_data[0] !== 512'd1 || rd_data[1] !== 512'd2 || rd_last[1] !== 1'b1 || rd_id !== 1'b0) begin
      n_fail++; $display("[TB] FAIL midrd_new_ar: got n=%0d d0=%0h d1=%0h last=%b id=%b expected 2 1 2 1 0", rd_n, rd_data[0], rd_data[1], rd_last[1], rd_id);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] bresp; logic [IW-1:0] bid; logic to, be;
    write_burst(42'h3FFC0, 1'b0, 8'd1, WRAP_BASE, '1, -1, bresp, bid, to, be);
    read_burst(42'h0, 1'b0, 8'd0);
    n_checks++;
    if (rd_data[0] !== WRAP_BASE + DW'(1)) begin
      n_fail++; $display("[TB] FAIL wrap_word0: got %h expected %h", rd_data[0], WRAP_BASE + DW'(1));
    end
    read_burst(42'h3FFC0, 1'b0, 8'd1);
    n_checks++;
    if (rd_n != 2 || rd_data[0] !== WRAP_BASE || rd_data[1] !== WRAP_BASE + DW'(1)) begin
      n_fail++; $display("[TB] FAIL wrap_read: got n=%0d d0=%h d1=%h", rd_n, rd_data[0], rd_data[1]);
    end
  endtask

  task automatic test_range();
    logic [1:0] bresp; logic [IW-1:0] bid; logic to, be;
    logic [DW-1:0] exp0, exp1, exp_w; logic [1:0] exp_r;
`ifdef AXI_GMEM_SLV_RANGE_CHECK_EN
    exp0 = '0; exp1 = '0; exp_r = 2'b10; exp_w = WRAP_BASE + DW'(1);
`else
    exp0 = WRAP_BASE + DW'(1); exp1 = 512'd1; exp_r = 2'b00; exp_w = 512'h9999;
`endif
    read_burst(42'h40000, 1'b0, 8'd1);
    n_checks++;
    if (rd_n != 2 || rd_data[0] !== exp0 || rd_data[1] !== exp1 || rd_resp[0] !== exp_r || rd_resp[1] !== exp_r) begin
      n_fail++; $display("[TB] FAIL range_read: got n=%0d r=%b/%b d0=%h expected resp %b d0 %h", rd_n, rd_resp[0], rd_resp[1], rd_data[0], exp_r, exp0);
    end
    write_burst(42'h40000, 1'b0, 8'd0, 512'h9999, '1, -1, bresp, bid, to, be);
    n_checks++;
    if (bresp !== exp_r || to !== 1'b0) begin
      n_fail++; $display("[TB] FAIL range_bresp: got %b to=%b expected %b 0", bresp, to, exp_r);
    end
    read_burst(42'h0, 1'b0, 8'd0);
    n_checks++;
    if (rd_data[0] !== exp_w) begin
      n_fail++; $display("[TB] FAIL range_word0: got %h expected %h", rd_data[0], exp_w);
    end
  endtask

  initial begin
    ap_rst = 1'b1;
    s_axi.AWVALID = 1'b0; s_axi.AWADDR = '0; s_axi.AWID = '0; s_axi.AWLEN = '0;
    s_axi.WVALID = 1'b0; s_axi.WDATA = '0; s_axi.WSTRB = '0; s_axi.WLAST = 1'b0;
    s_axi.BREADY = 1'b0;
    s_axi.ARVALID = 1'b0; s_axi.ARADDR = '0; s_axi.ARID = '0; s_axi.ARLEN = '0;
    s_axi.RREADY = 1'b0;
    @(negedge ap_clk);
    test_reset();
    test_burst_rw();
    test_strobe();
    test_read_stall();
    test_wlast_err();
    test_reset_mid_read();
    test_wrap();
    test_range();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
